// File: rtl/bingo_guess_engine.sv
// Bingo board guess engine: takes one number per round from the local
// player (BCD) or the peer board (binary), marks it and counts lines.
module bingo_guess_engine #(
    parameter int BOARD_DIM      = 5,
    parameter int WIN_LINES      = 5,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 interboard_rst,
    input  logic                                 start_guess,
    input  logic                                 clear_guess,
    input  logic                                 local_turn,
    input  logic [7:0]                           cur_number_BCD,
    input  logic                                 enter_pulse,
    input  logic                                 remote_valid,
    input  logic [6:0]                           remote_number,
    output logic [BOARD_DIM*BOARD_DIM-1:0]       circle,
    output logic                                 guess_done,
    output logic                                 guess_accept,
    output logic                                 guess_reject,
    output logic                                 timed_out,
    output logic [6:0]                           last_number,
    output logic [4:0]                           line_count,
    output logic                                 bingo
);
    localparam int CELLS = BOARD_DIM * BOARD_DIM;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CELLS-1:0] ONE = CELLS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CELLS-1:0] circle_q, circle_d;
    logic [6:0]       last_q, last_d;
    logic [4:0]       lines_q, lines_d;
    logic             bingo_q, bingo_d;
    logic             acc_q, acc_d;
    logic             rej_q, rej_d;
    logic             to_q, to_d;
    logic [TW-1:0]    cnt_q, cnt_d;

    logic [3:0]       tens, ones;
    logic [6:0]       loc_n, mark_n;
    logic [CELLS-1:0] loc_mask, rem_mask, mark_mask;
    logic             loc_legal, rem_legal, mark;

    // Empty mask means the number is out of board range.
    function automatic logic [CELLS-1:0] cell_mask(input logic [6:0] n);
        if (n != 7'd0 && int'(n) <= CELLS)
            return ONE << (n - 7'd1);
        return '0;
    endfunction

    assign tens      = cur_number_BCD[7:4];
    assign ones      = cur_number_BCD[3:0];
    assign loc_n     = {3'b0, tens} * 7'd10 + {3'b0, ones};
    assign loc_mask  = cell_mask(loc_n);
    assign rem_mask  = cell_mask(remote_number);
    assign loc_legal = (tens <= 4'd9) && (ones <= 4'd9) &&
                       (|loc_mask) && ~|(circle_q & loc_mask);
    assign rem_legal = (|rem_mask) && ~|(circle_q & rem_mask);

    always_comb begin
        state_d   = state_q;
        circle_d  = circle_q;
        last_d    = last_q;
        acc_d     = 1'b0;
        rej_d     = 1'b0;
        to_d      = to_q;
        cnt_d     = cnt_q;
        mark      = 1'b0;
        mark_n    = 7'd0;
        mark_mask = '0;
        unique case (state_q)
            IDLE: begin
                if (start_guess) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + TW'(1);
                if (local_turn) begin
                    if (enter_pulse && loc_legal) begin
                        mark      = 1'b1;
                        mark_n    = loc_n;
                        mark_mask = loc_mask;
                    end else if (enter_pulse) begin
                        rej_d = 1'b1;
                    end
                end else if (remote_valid) begin
                    state_d = FIN;
                    if (rem_legal) begin
                        mark      = 1'b1;
                        mark_n    = remote_number;
                        mark_mask = rem_mask;
                    end
                end
                if (mark) begin
                    acc_d   = 1'b1;
                    state_d = FIN;
                end else if (TIMEOUT_CYCLES > 0 && cnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_guess) begin
            circle_d = '0;
            last_d   = 7'd0;
        end else if (mark) begin
            circle_d = circle_q | mark_mask;
            last_d   = mark_n;
        end
    end

    // Line counter works on the registered board, hence the one-cycle lag.
    logic row, col, diag, anti;
    always_comb begin
        lines_d = 5'd0;
        row     = 1'b0;
        col     = 1'b0;
        diag    = 1'b1;
        anti    = 1'b1;
        for (int r = 0; r < BOARD_DIM; r++) begin
            row = 1'b1;
            col = 1'b1;
            for (int k = 0; k < BOARD_DIM; k++) begin
                row = row & circle_q[r*BOARD_DIM+k];
                col = col & circle_q[k*BOARD_DIM+r];
            end
            diag    = diag & circle_q[r*BOARD_DIM+r];
            anti    = anti & circle_q[r*BOARD_DIM+BOARD_DIM-1-r];
            lines_d = lines_d + {4'b0, row} + {4'b0, col};
        end
        lines_d = lines_d + {4'b0, diag} + {4'b0, anti};
        if (clear_guess)
            lines_d = 5'd0;
    end

    assign bingo_d = !clear_guess && (int'(lines_q) >= WIN_LINES);

    always_ff @(posedge clk) begin
        if (rst || interboard_rst) begin
            state_q  <= IDLE;
            circle_q <= '0;
            last_q   <= 7'd0;
            lines_q  <= 5'd0;
            bingo_q  <= 1'b0;
            acc_q    <= 1'b0;
            rej_q    <= 1'b0;
            to_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            circle_q <= circle_d;
            last_q   <= last_d;
            lines_q  <= lines_d;
            bingo_q  <= bingo_d;
            acc_q    <= acc_d;
            rej_q    <= rej_d;
            to_q     <= to_d;
            cnt_q    <= cnt_d;
        end
    end

    assign circle       = circle_q;
    assign guess_done   = (state_q == FIN);
    assign guess_accept = acc_q;
    assign guess_reject = rej_q;
    assign timed_out    = to_q;
    assign last_number  = last_q;
    assign line_count   = lines_q;
    assign bingo        = bingo_q;
endmodule
